// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between CPU (fixed priority), UART loader and debug reader.
// Loader/debug share idle cycles round-robin and preempt the CPU for one cycle once starved.
module data_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ldr_req,
  input  logic [31:0]       ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_ack,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DBG = 2'd2} owner_e;

  logic [CNT_W-1:0] ldr_cnt_q, ldr_cnt_d, dbg_cnt_q, dbg_cnt_d;
  logic             rr_q, rr_d;  // 0: loader preferred, 1: debug preferred
  owner_e           owner_q, owner_d;
  logic             cpu_gnt, ldr_gnt, dbg_gnt;
  logic             ldr_starved, dbg_starved;

  assign ldr_starved = ldr_req && (ldr_cnt_q == LIMIT);
  assign dbg_starved = dbg_req && (dbg_cnt_q == LIMIT);

  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (ldr_starved && dbg_starved) begin
        ldr_gnt = !rr_q;
        dbg_gnt = rr_q;
      end else if (ldr_starved) begin
        ldr_gnt = 1'b1;
      end else if (dbg_starved) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ldr_req && dbg_req) begin
        ldr_gnt = !rr_q;
        dbg_gnt = rr_q;
      end else begin
        ldr_gnt = ldr_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt || ldr_gnt || dbg_gnt;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we ? cpu_be : 4'h0;
      owner_d   = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (ldr_gnt) begin
      mem_addr  = ldr_addr[ADDR_W+1:2];
      mem_wdata = ldr_wdata;
      mem_we    = 4'hF;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr[ADDR_W+1:2];
      owner_d   = OWN_DBG;
    end
  end

  always_comb begin
    rr_d = (ldr_gnt || dbg_gnt) ? !rr_q : rr_q;

    if (!ldr_req || ldr_gnt)   ldr_cnt_d = '0;
    else if (ldr_cnt_q != LIMIT) ldr_cnt_d = ldr_cnt_q + 1'b1;
    else                       ldr_cnt_d = ldr_cnt_q;

    if (!dbg_req || dbg_gnt)   dbg_cnt_d = '0;
    else if (dbg_cnt_q != LIMIT) dbg_cnt_d = dbg_cnt_q + 1'b1;
    else                       dbg_cnt_d = dbg_cnt_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ldr_cnt_q <= '0;
      dbg_cnt_q <= '0;
      rr_q      <= 1'b0;
      owner_q   <= OWN_NONE;
    end else begin
      ldr_cnt_q <= ldr_cnt_d;
      dbg_cnt_q <= dbg_cnt_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
    end
  end

  // Read returns are masked during reset so an in-flight read is dropped.
  assign cpu_stall  = cpu_req && !cpu_gnt && !rst;
  assign ldr_ack    = ldr_gnt;
  assign dbg_ack    = dbg_gnt;
  assign cpu_rvalid = (owner_q == OWN_CPU) && !rst;
  assign dbg_rvalid = (owner_q == OWN_DBG) && !rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              ldr_addr[31:ADDR_W+2], ldr_addr[1:0],
                              dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

endmodule
